dmem_arb: RTL and testbench
===========================

Name: dmem_arb

Overview:
- Arbiter and boot sequencer for the four byte-lane data memories (lanes 0..3 = bits 7:0..31:24).
- Shares the single memory port between the nanorv32 CPU data port and a host/loader port (UART or JTAG boot loader).
- After reset it holds the CPU and gives the host exclusive access so the host can load the program image. It then releases the CPU and arbitrates with CPU priority plus a starvation guard for the host.

Parameters:
- AW, 12, word address width (4*2^AW bytes of dmem)
- STARVE_MAX, 4, consecutive host wait cycles after which the host wins the next arbitration; legal range 1..15

Ports:
- clk  in  1  system clock
- reset_l  in  1  synchronous active-low reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1=write, 0=read
- cpu_be  in  4  byte enables, bit n = lane n (writes only)
- cpu_addr  in  AW  word address
- cpu_wdata  in  32  write data
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  read data valid
- cpu_rdata  out  32  read data
- host_req, host_we, host_be, host_addr, host_wdata  in  same widths and meanings as the cpu_ equivalents
- host_gnt, host_rvalid, host_rdata  out  same widths and meanings as the cpu_ equivalents
- host_boot_done  in  1  one-cycle pulse: loading finished, release CPU
- cpu_hold  out  1  keeps nanorv32 in reset/stall while 1
- mem_addr  out  AW  address to all four lanes
- mem_we  out  4  per-lane write strobe
- mem_wdata  out  32  write data (lane n gets bits 8n+7:8n)
- mem_rdata  in  32  concatenated lane read data, valid the cycle after the address is presented (synchronous RAM)

Behaviour:
- Clock and reset: one clock domain, clk. reset_l is synchronous and active-low.
- Reset values: state=BOOT, cpu_hold=1, starve_cnt=0, both rvalid=0, both gnt=0, mem_we=0. mem_addr and mem_wdata are don't-care.
- Reset mid-operation: any pending read return is dropped (rvalid stays 0). No write is issued in the reset cycle.
- State BOOT:
  - Only the host is served. cpu_gnt=0 regardless of cpu_req.
  - cpu_hold=1.
  - host_boot_done=1 moves to RUN next cycle. A host request in the same cycle is still served.
- State RUN:
  - cpu_hold=0.
  - RUN is left only by reset.
  - host_boot_done is ignored in RUN.
- Grant timing:
  - gnt is combinational, in the same cycle as req.
  - mem_addr, mem_we and mem_wdata are driven from the granted port in that cycle.
  - At most one gnt per cycle.
  - No request: mem_we=0.
- Arbitration in RUN:
  - Default winner is the CPU.
  - The host wins if the CPU is not requesting, or if starve_cnt >= STARVE_MAX.
- starve_cnt:
  - Increments (saturating at 15) every cycle with host_req=1 and host_gnt=0.
  - Clears to 0 on host_gnt and when host_req=0.
- Writes:
  - mem_we = be when we=1, otherwise 0.
  - be=0 is granted and consumes the slot but writes nothing.
  - Writes never produce rvalid.
- Reads:
  - we=0; be is ignored and all lanes are read.
  - Latency is 1: the granted port's rvalid=1 exactly one cycle after gnt.
  - rdata = mem_rdata in that cycle.
  - A one-bit owner register records the port that owns the return.
  - The non-owning port's rvalid=0; its rdata holds its last value.
- Back-to-back: a new grant may occur in the same cycle as the previous read's rvalid (fully pipelined, one access per cycle).
- Read-after-write: a read to the same address in the cycle after a write returns the new data. This relies on the RAM's write-then-read-next-cycle property; no bypass logic is added.

Decomposition:
- Shared package dmem_pkg holds:
  - lane count (4), lane width (8)
  - state encoding (BOOT, RUN)
  - port-id constants (PORT_CPU, PORT_HOST)
- One natural sub-module, dmem_arb_starve: the saturating starvation counter and its compare, instantiated once.

Test Plan:
- Boot load: after reset, host writes 0xDEADBEEF to addr 0x010 with be=1111 while cpu_req=1. Required: host_gnt=1, cpu_gnt=0, cpu_hold=1, mem_we=1111. Then pulse host_boot_done; the next cycle shows cpu_hold=0.
- Byte lanes: in RUN, CPU writes 0x000000AA with be=0001, then 0x0000BB00 with be=0010, to addr 0x020, then reads it. Required: cpu_rvalid one cycle after gnt, with rdata[15:0]=0xBBAA and the upper bytes unchanged from the preload.
- Starvation: cpu_req held high continuously, host_req=1 from cycle t, STARVE_MAX=4. Required: cpu_gnt in cycles t..t+3, host_gnt in cycle t+4, CPU granted again at t+5, starve_cnt=0 after the host grant.
- Pipelined reads: CPU reads addr 1, 2, 3 on consecutive cycles. Required: three gnts on consecutive cycles and rvalid on the following three cycles with matching data; host_rvalid stays 0 throughout.
- Reset mid-read: assert reset_l=0 in the cycle after a granted host read. Required: host_rvalid=0, state=BOOT, cpu_hold=1 on the next cycle.
- be=0 write and idle: CPU write with be=0000 → cpu_gnt=1, mem_we=0000, memory unchanged. No requests → mem_we=0 and both gnt=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter: lane geometry,
// arbiter state encoding and port identifiers.
package dmem_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;
endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating count of consecutive cycles the host has waited; flags when
// the host must win the next arbitration.
module dmem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_l,
  input  logic host_req_i,
  input  logic host_gnt_i,
  output logic starved_o
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = 4'd0;
    if (host_req_i && !host_gnt_i) begin
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q >= 4'(STARVE_MAX));
endmodule

// File: rtl/dmem_arb.sv
// Shares the byte-lane data memory between the CPU and the boot host; the
// host owns memory until boot completes, then the CPU has priority.
module dmem_arb
  import dmem_pkg::*;
#(
  parameter int AW         = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [LANES-1:0]          cpu_be,
  input  logic [AW-1:0]             cpu_addr,
  input  logic [LANES*LANE_W-1:0]   cpu_wdata,
  output logic                      cpu_gnt,
  output logic                      cpu_rvalid,
  output logic [LANES*LANE_W-1:0]   cpu_rdata,
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [LANES-1:0]          host_be,
  input  logic [AW-1:0]             host_addr,
  input  logic [LANES*LANE_W-1:0]   host_wdata,
  output logic                      host_gnt,
  output logic                      host_rvalid,
  output logic [LANES*LANE_W-1:0]   host_rdata,
  input  logic                      host_boot_done,
  output logic                      cpu_hold,
  output logic [AW-1:0]             mem_addr,
  output logic [LANES-1:0]          mem_we,
  output logic [LANES*LANE_W-1:0]   mem_wdata,
  input  logic [LANES*LANE_W-1:0]   mem_rdata
);
  state_e                    state_q, state_d;
  logic                      starved;
  logic                      rd_issue;
  logic                      owner_d, owner_q;
  logic                      rvalid_q;
  logic [LANES*LANE_W-1:0]   cpu_rdata_q, host_rdata_q;

  dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .reset_l    (reset_l),
    .host_req_i (host_req),
    .host_gnt_i (host_gnt),
    .starved_o  (starved)
  );

  // Nothing is granted while reset is asserted, so no write can slip out.
  always_comb begin
    state_d  = state_q;
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (reset_l) begin
      case (state_q)
        BOOT: begin
          host_gnt = host_req;
          if (host_boot_done) state_d = RUN;
        end
        RUN: begin
          if (host_req && (!cpu_req || starved)) host_gnt = 1'b1;
          else                                   cpu_gnt  = cpu_req;
        end
      endcase
    end
  end

  assign cpu_hold = (state_q == BOOT);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = '0;
    rd_issue  = 1'b0;
    owner_d   = PORT_CPU;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we ? host_be : '0;
      rd_issue  = !host_we;
      owner_d   = PORT_HOST;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we ? cpu_be : '0;
      rd_issue  = !cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q  <= BOOT;
      rvalid_q <= 1'b0;
      owner_q  <= PORT_CPU;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rd_issue;
      owner_q  <= owner_d;
    end
  end

  // A return in flight when reset arrives is suppressed, not delivered late.
  assign cpu_rvalid  = reset_l && rvalid_q && (owner_q == PORT_CPU);
  assign host_rvalid = reset_l && rvalid_q && (owner_q == PORT_HOST);

  always_ff @(posedge clk) begin
    if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
    if (host_rvalid) host_rdata_q <= mem_rdata;
  end

  assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
  assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;
endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed boot/lane/starvation/pipeline/reset steps and
// a random phase, all checked against a rule-level reference model.
module tb_dmem_arb;
  import dmem_pkg::*;

  localparam int AW         = 12;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            reset_l;
  logic            cpu_req, cpu_we, host_req, host_we, host_boot_done;
  logic [3:0]      cpu_be, host_be, mem_we;
  logic [AW-1:0]   cpu_addr, host_addr, mem_addr;
  logic [31:0]     cpu_wdata, host_wdata, mem_wdata, mem_rdata;
  logic            cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, cpu_hold;
  logic [31:0]     cpu_rdata, host_rdata;

  logic [31:0]     ram     [0:(1<<AW)-1];
  logic [31:0]     ref_mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  bit          m_boot, m_pend_v, m_pend_host, m_seen_cpu, m_seen_host;
  int          m_starve;
  logic [31:0] m_pend_data, m_last_cpu, m_last_host;

  always #10 clk = ~clk;

  dmem_arb #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_l(reset_l),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_be(host_be), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_boot_done(host_boot_done), .cpu_hold(cpu_hold),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous byte-lane RAM: registered read, writes visible next cycle.
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (mem_we[n]) ram[mem_addr][8*n +: 8] <= mem_wdata[8*n +: 8];
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [3:0] be,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_host(input bit req, input bit we, input logic [3:0] be,
                          input logic [AW-1:0] addr, input logic [31:0] wd);
    host_req = req; host_we = we; host_be = be; host_addr = addr; host_wdata = wd;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    bit eh, ec, ecv, ehv, ew;
    logic [3:0]    ewe;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    #2;
    eh = 0; ec = 0;
    if (reset_l) begin
      if (m_boot)                                                  eh = host_req;
      else if (host_req && (!cpu_req || m_starve >= STARVE_MAX))   eh = 1;
      else                                                         ec = cpu_req;
    end
    ew  = eh ? host_we : (ec ? cpu_we : 1'b0);
    ewe = eh ? (host_we ? host_be : 4'h0) : (ec ? (cpu_we ? cpu_be : 4'h0) : 4'h0);
    ea  = eh ? host_addr : cpu_addr;
    ed  = eh ? host_wdata : cpu_wdata;
    ecv = reset_l && m_pend_v && !m_pend_host;
    ehv = reset_l && m_pend_v &&  m_pend_host;

    chk("cpu_gnt",  cpu_gnt,  ec);
    chk("host_gnt", host_gnt, eh);
    chk("mem_we",   mem_we,   ewe);
    if (eh || ec) chk("mem_addr", mem_addr, ea);
    if (ew && (eh || ec)) chk("mem_wdata", mem_wdata, ed);
    chk("cpu_hold", cpu_hold, m_boot);
    chk("state", 32'(dut.state_q), m_boot ? 32'(BOOT) : 32'(RUN));
    chk("starve_cnt", 32'(dut.u_starve.cnt_q), m_starve);
    chk("cpu_rvalid",  cpu_rvalid,  ecv);
    chk("host_rvalid", host_rvalid, ehv);
    if (ecv)             chk("cpu_rdata", cpu_rdata, m_pend_data);
    else if (m_seen_cpu) chk("cpu_rdata_hold", cpu_rdata, m_last_cpu);
    if (ehv)              chk("host_rdata", host_rdata, m_pend_data);
    else if (m_seen_host) chk("host_rdata_hold", host_rdata, m_last_host);

    @(posedge clk);
    if (ecv) begin m_last_cpu  = m_pend_data; m_seen_cpu  = 1; end
    if (ehv) begin m_last_host = m_pend_data; m_seen_host = 1; end
    if (!reset_l) begin
      m_boot = 1; m_starve = 0; m_pend_v = 0;
    end else begin
      m_pend_v    = (eh || ec) && !ew;
      m_pend_host = eh;
      if (m_pend_v) m_pend_data = ref_mem[ea];
      if (ew) for (int n = 0; n < 4; n++)
        if (ewe[n]) ref_mem[ea][8*n +: 8] = ed[8*n +: 8];
      m_starve = (host_req && !eh) ? ((m_starve == 15) ? 15 : m_starve + 1) : 0;
      if (m_boot && host_boot_done) m_boot = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin ram[i] = '0; ref_mem[i] = '0; end
    m_boot = 1; m_starve = 0; m_pend_v = 0; m_pend_host = 0;
    m_seen_cpu = 0; m_seen_host = 0; m_pend_data = '0; m_last_cpu = '0; m_last_host = '0;
    reset_l = 0; host_boot_done = 0;
    set_cpu(0, 0, 4'h0, '0, '0);
    set_host(0, 0, 4'h0, '0, '0);
    @(negedge clk);

    // Reset
    cycle(); cycle();
    reset_l = 1;
    cycle();

    // Boot load while the CPU is already knocking
    set_cpu(1, 1, 4'hF, 12'h010, 32'h0BADF00D);
    set_host(1, 1, 4'hF, 12'h010, 32'hDEADBEEF);
    #1 chk("boot_host_gnt", host_gnt, 1'b1);
    chk("boot_cpu_gnt", cpu_gnt, 1'b0);
    chk("boot_mem_we", mem_we, 4'hF);
    cycle();
    set_host(1, 1, 4'hF, 12'h020, 32'h11223344); cycle();
    set_host(1, 1, 4'hF, 12'h001, 32'hA1A1A1A1); cycle();
    set_host(1, 1, 4'hF, 12'h002, 32'hB2B2B2B2); cycle();
    set_host(1, 1, 4'hF, 12'h003, 32'hC3C3C3C3); host_boot_done = 1; cycle();
    set_host(0, 0, 4'h0, '0, '0); host_boot_done = 0;
    set_cpu(0, 0, 4'h0, '0, '0);
    #1 chk("run_cpu_hold", cpu_hold, 1'b0);
    cycle();

    // Byte lanes
    set_cpu(1, 1, 4'b0001, 12'h020, 32'h000000AA); cycle();
    set_cpu(1, 1, 4'b0010, 12'h020, 32'h0000BB00); cycle();
    set_cpu(1, 0, 4'b0000, 12'h020, '0);           cycle();
    set_cpu(0, 0, 4'h0, '0, '0);
    #1 chk("lane_rvalid", cpu_rvalid, 1'b1);
    chk("lane_rdata", cpu_rdata, 32'h1122BBAA);
    cycle();

    // Starvation: CPU continuously requesting, host waits STARVE_MAX cycles
    set_cpu(1, 0, 4'h0, 12'h001, '0);
    set_host(1, 0, 4'h0, 12'h002, '0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) set_host(0, 0, 4'h0, '0, '0);
      #1 chk("starve_host_gnt", host_gnt, (i == 4));
      chk("starve_cpu_gnt", cpu_gnt, (i != 4));
      cycle();
    end
    chk("starve_cleared", 32'(dut.u_starve.cnt_q), 0);

    // Pipelined reads
    set_cpu(1, 0, 4'h0, 12'h001, '0); cycle();
    set_cpu(1, 0, 4'h0, 12'h002, '0); cycle();
    set_cpu(1, 0, 4'h0, 12'h003, '0); cycle();
    set_cpu(0, 0, 4'h0, '0, '0);
    #1 chk("pipe_last_rdata", cpu_rdata, 32'hC3C3C3C3);
    cycle();

    // be=0 write, read-back, idle
    set_cpu(1, 1, 4'h0, 12'h020, 32'hFFFFFFFF);
    #1 chk("be0_gnt", cpu_gnt, 1'b1);
    chk("be0_mem_we", mem_we, 4'h0);
    cycle();
    set_cpu(1, 0, 4'h0, 12'h020, '0); cycle();
    set_cpu(0, 0, 4'h0, '0, '0);
    #1 chk("be0_unchanged", cpu_rdata, 32'h1122BBAA);
    chk("idle_cpu_gnt", cpu_gnt, 1'b0);
    chk("idle_host_gnt", host_gnt, 1'b0);
    chk("idle_mem_we", mem_we, 4'h0);
    cycle();

    // Random traffic with occasional reset and boot release
    for (int i = 0; i < 400; i++) begin
      reset_l        = ($urandom_range(0, 59) != 0);
      host_boot_done = ($urandom_range(0, 14) == 0);
      set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1), 4'($urandom),
              AW'($urandom_range(0, 31)), $urandom);
      set_host($urandom_range(0, 2) != 0, $urandom_range(0, 1), 4'($urandom),
               AW'($urandom_range(0, 31)), $urandom);
      cycle();
    end

    // Reset mid-read
    reset_l = 0; host_boot_done = 0;
    set_cpu(0, 0, 4'h0, '0, '0); set_host(0, 0, 4'h0, '0, '0);
    cycle();
    reset_l = 1;
    set_host(1, 0, 4'h0, 12'h010, '0); cycle();
    reset_l = 0;
    set_host(0, 0, 4'h0, '0, '0); cycle();
    reset_l = 1;
    #1 chk("rst_host_rvalid", host_rvalid, 1'b0);
    chk("rst_cpu_hold", cpu_hold, 1'b1);
    chk("rst_state", 32'(dut.state_q), 32'(BOOT));
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
